// File: rtl/alsu_negative_flag_tracker.sv
// -----------------------------------------------------------------------------
// alsu_negative_flag_tracker
//
// Purpose:
//   Watches the result stream of an ALSU.
//   - Registers the negative flag that belongs to the current operation
//     (the adder or the decrementer flag, chosen by Sel).
//   - Registers a zero flag for the last captured Result.
//   - Keeps a sticky "a negative result was seen" flag.
//   - Keeps a saturating count of negative results.
//   A small three-state FSM (ACTIVE / SATURATED / FROZEN) decides when a
//   result may be captured and reports saturation and freeze status.
//
// Ports:
//   clk                            in   rising-edge clock
//   rst                            in   asynchronous active-high reset
//   Sel[3:0]                       in   ALSU operation select
//   Valid_In                       in   Sel/Result/flags describe a valid result
//   Result[WIDTH-1:0]              in   ALSU result word
//   Negative_Sign_Adder_Flag       in   adder negative flag
//   Negative_Sign_Decrementer_Flag in   decrementer negative flag
//   Freeze                         in   level request to stop capturing
//   Clear                          in   synchronous clear of sticky/count
//   Negative_Sign_Flag             out  negative flag of last capture
//   Zero_Flag                      out  last captured Result was zero
//   Valid_Out                      out  one-cycle pulse after a capture
//   Sticky_Negative_Flag           out  negative capture seen since Clear
//   Negative_Count[CNT_W-1:0]      out  saturating negative-capture count
//   Count_Saturated                out  FSM is in SATURATED
//   Frozen                         out  FSM is in FROZEN
// -----------------------------------------------------------------------------
module alsu_negative_flag_tracker #(
  parameter int         WIDTH   = 4,
  parameter int         CNT_W   = 8,
  parameter logic [3:0] ADD_SEL = 4'b0000,
  parameter logic [3:0] DEC_SEL = 4'b1100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Sel,
  input  logic             Valid_In,
  input  logic [WIDTH-1:0] Result,
  input  logic             Negative_Sign_Adder_Flag,
  input  logic             Negative_Sign_Decrementer_Flag,
  input  logic             Freeze,
  input  logic             Clear,
  output logic             Negative_Sign_Flag,
  output logic             Zero_Flag,
  output logic             Valid_Out,
  output logic             Sticky_Negative_Flag,
  output logic [CNT_W-1:0] Negative_Count,
  output logic             Count_Saturated,
  output logic             Frozen
);

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    SATURATED = 2'd1,
    FROZEN    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic sel_flag;
  logic capture;

  // The decrementer code is checked first so it wins if both parameters
  // were ever set to the same code.
  always_comb begin
    sel_flag = 1'b0;
    if (Sel == DEC_SEL) begin
      sel_flag = Negative_Sign_Decrementer_Flag;
    end else if (Sel == ADD_SEL) begin
      sel_flag = Negative_Sign_Adder_Flag;
    end
  end

  // Freeze blocks capture on the very edge it is first seen, and FROZEN
  // also blocks capture on the edge that leaves it.
  assign capture = Valid_In && !Freeze && (state_q != FROZEN);

  // Datapath next-state: flags, sticky bit and saturating counter.
  // Clear beats a same-edge negative capture for sticky/count only.
  always_comb begin
    neg_d    = neg_q;
    zero_d   = zero_q;
    valid_d  = capture;
    sticky_d = sticky_q;
    count_d  = count_q;

    if (capture) begin
      neg_d  = sel_flag;
      zero_d = (Result == '0);
    end

    if (Clear) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (capture && sel_flag) begin
      sticky_d = 1'b1;
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // FSM next-state. Decisions use count_d so that a same-edge Clear or
  // capture is already reflected in where the FSM lands.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACTIVE: begin
        if (Freeze) begin
          state_d = FROZEN;
        end else if (!Clear && (count_d == CNT_MAX)) begin
          state_d = SATURATED;
        end
      end
      SATURATED: begin
        if (Freeze) begin
          state_d = FROZEN;
        end else if (Clear) begin
          state_d = ACTIVE;
        end
      end
      FROZEN: begin
        if (!Freeze) begin
          state_d = (count_d == CNT_MAX) ? SATURATED : ACTIVE;
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACTIVE;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign Negative_Sign_Flag   = neg_q;
  assign Zero_Flag            = zero_q;
  assign Valid_Out            = valid_q;
  assign Sticky_Negative_Flag = sticky_q;
  assign Negative_Count       = count_q;
  assign Count_Saturated      = (state_q == SATURATED);
  assign Frozen               = (state_q == FROZEN);

endmodule
